// File: rtl/j11busif2.sv
// j11busif2: DCJ11 bus interface with configurable clock divider, DAL phase length and bus timeout
module j11busif2 #(
    parameter int CLKDIV  = 5,
    parameter int PH      = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [15:0] j11f,
    output logic        j11clk,
    output logic        j11dmr,
    output logic        j11miss,
    output logic        j11cont,
    output logic        j11dv,
    output logic        j11abortout,
    output logic [3:0]  j11dsel,
    input  logic        j11ale,
    input  logic        j11strb,
    input  logic        j11sctl,
    input  logic        j11map,
    input  logic [9:0]  j11hi,
    output logic        busreq,
    output logic        buswr,
    output logic        busgp,
    output logic        busirq,
    output logic [21:0] busaddr,
    output logic [15:0] buswdata,
    input  logic        busack,
    input  logic [15:0] busrdata,
    output logic        busto,
    output logic [4:0]  j11state
);
    localparam int DW = $clog2(CLKDIV);
    localparam int PW = $clog2(2 * PH + 4);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [3:0] D_NONE = 4'b1100, D_INHI = 4'b0100, D_INLO = 4'b1000, D_OUTHI = 4'b1110, D_OUTLO = 4'b1101;

    typedef enum logic [4:0] {
        S_INIT, S_IDLE, S_WAITALE, S_ADDR, S_RDREQ, S_RDOUT, S_RDEND0, S_RDEND1,
        S_WRWAIT, S_WRREQ, S_WREND, S_OUTHI
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_pc;
    logic [DW-1:0] r_div;
    logic [TW-1:0] r_to;
    logic          r_clk, r_strb_p, r_init_d, r_abf;
    logic [1:0]    r_ale_s, r_strb_s, r_sctl_s, r_map_s;
    logic [9:0]    r_hi0;
    logic [15:0]   r_fout, r_buswdata;
    logic [21:0]   r_busaddr;
    logic [3:0]    r_aio;
    logic          r_busreq, r_buswr, r_busgp, r_busirq, r_busto, r_abort;
    logic          w_ale, w_strb, w_sctl, w_hichg, w_initfall, w_ack, w_exp, w_ph1, w_ph2, w_fdrive, w_unused;

    assign w_ale      = r_ale_s[1];
    assign w_strb     = r_strb_s[1];
    assign w_sctl     = r_sctl_s[1];
    assign w_hichg    = j11hi != r_hi0;
    assign w_initfall = r_init_d & ~j11hi[6];
    assign w_ack      = r_busreq & busack;
    assign w_exp      = r_busreq & ~busack & (TIMEOUT != 0) & (r_to == TW'(TIMEOUT));
    assign w_ph1      = (r_pc != '0) && (r_pc <= PW'(PH));
    assign w_ph2      = (r_pc >= PW'(PH + 3)) && (r_pc <= PW'(2 * PH + 2));
    assign w_fdrive   = (r_state == S_RDOUT) || (r_state == S_OUTHI);
    assign w_unused   = &{1'b0, r_map_s, r_abf};

    assign j11f        = w_fdrive ? r_fout : 16'bz;
    assign j11clk      = r_clk;
    assign j11dmr      = 1'b1;
    assign j11miss     = 1'b0;
    assign j11cont     = !((r_state == S_RDEND1) || (r_state == S_WREND));
    assign j11dv       = r_state == S_RDEND1;
    assign j11abortout = r_abort;
    assign j11dsel     = (r_state == S_ADDR && w_ph1) ? D_INHI :
                         ((r_state == S_ADDR && w_ph2) || r_state == S_WRWAIT) ? D_INLO :
                         (r_state == S_RDOUT && w_ph1) ? D_OUTLO :
                         (r_state == S_OUTHI && w_ph1) ? D_OUTHI : D_NONE;
    assign busreq      = r_busreq;
    assign buswr       = r_buswr;
    assign busgp       = r_busgp;
    assign busirq      = r_busirq;
    assign busaddr     = r_busaddr;
    assign buswdata    = r_buswdata;
    assign busto       = r_busto;
    assign j11state    = r_state;

    // free-running J11 clock divider
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_clk <= 1'b0;
        end else begin
            r_div <= (r_div == DW'(CLKDIV - 1)) ? '0 : r_div + 1'b1;
            r_clk <= (r_div == DW'(CLKDIV - 1)) ? ~r_clk : r_clk;
        end
    end

    // two-flop synchronisers for the asynchronous J11 control pins, preset high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ale_s  <= 2'b11;
            r_strb_s <= 2'b11;
            r_sctl_s <= 2'b11;
            r_map_s  <= 2'b11;
        end else begin
            r_ale_s  <= {r_ale_s[0], j11ale};
            r_strb_s <= {r_strb_s[0], j11strb};
            r_sctl_s <= {r_sctl_s[0], j11sctl};
            r_map_s  <= {r_map_s[0], j11map};
        end
    end

    // bus-cycle FSM: DAL phase sequencing, system-bus handshake with timeout, status presentation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_pc       <= '0;
            r_to       <= '0;
            r_strb_p   <= 1'b1;
            r_init_d   <= 1'b0;
            r_hi0      <= '0;
            r_fout     <= '0;
            r_busaddr  <= '0;
            r_buswdata <= '0;
            r_aio      <= '0;
            r_abf      <= 1'b0;
            r_busreq   <= 1'b0;
            r_buswr    <= 1'b0;
            r_busgp    <= 1'b0;
            r_busirq   <= 1'b0;
            r_busto    <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_busto  <= 1'b0;
            r_pc     <= r_pc + 1'b1;
            r_init_d <= j11hi[6];
            r_strb_p <= w_strb;
            if (w_initfall) begin
                r_state  <= S_OUTHI;
                r_pc     <= '0;
                r_busreq <= 1'b0;
            end else begin
                case (r_state)
                    S_INIT: if (w_hichg) begin
                        r_state <= S_OUTHI;
                        r_pc    <= '0;
                    end
                    S_IDLE: if ((w_strb & ~r_strb_p) || w_hichg) begin
                        r_state <= (w_strb & ~r_strb_p) ? S_WAITALE : S_OUTHI;
                        r_pc    <= '0;
                    end
                    S_WAITALE: if (!w_ale) begin
                        r_state <= S_ADDR;
                        r_pc    <= '0;
                    end
                    S_ADDR: begin
                        if (r_pc == PW'(PH)) begin
                            r_busaddr[21:16] <= j11f[5:0];
                            r_aio            <= j11f[11:8];
                            r_abf            <= j11f[13];
                            r_busgp          <= (j11f[11:8] == 4'b1110) || (j11f[11:8] == 4'b0101);
                            r_busirq         <= j11f[11:8] == 4'b1101;
                        end
                        if (r_pc == PW'(2 * PH + 2)) r_busaddr[15:0] <= j11f;
                        if (r_pc == PW'(2 * PH + 3)) begin
                            r_state <= (r_aio == 4'b1111) ? S_WREND : r_aio[3] ? S_RDREQ : S_WRWAIT;
                            r_pc    <= '0;
                        end
                    end
                    S_RDREQ, S_WRREQ: begin
                        r_busreq <= !(w_ack || w_exp);
                        r_buswr  <= r_state == S_WRREQ;
                        r_to     <= r_busreq ? r_to + 1'b1 : TW'(1);
                        if (w_exp) begin
                            r_abort <= 1'b1;
                            r_busto <= 1'b1;
                        end
                        if (w_ack || w_exp) begin
                            r_state <= (r_state == S_RDREQ) ? S_RDOUT : S_WREND;
                            r_pc    <= '0;
                            r_fout  <= (r_state != S_RDREQ) ? r_fout : w_ack ? busrdata : 16'hFFFF;
                        end
                    end
                    S_RDOUT: if (r_pc == PW'(PH + 1)) begin
                        r_state <= S_RDEND0;
                        r_pc    <= '0;
                    end
                    S_RDEND0: if (!w_sctl) begin
                        r_state <= S_RDEND1;
                        r_pc    <= '0;
                    end
                    S_RDEND1, S_WREND: if (w_sctl) begin
                        r_state <= w_hichg ? S_OUTHI : S_IDLE;
                        r_abort <= w_hichg & r_abort;
                        r_pc    <= '0;
                    end
                    S_WRWAIT: begin
                        r_buswdata <= j11f;
                        if (!w_sctl) begin
                            r_state <= S_WRREQ;
                            r_pc    <= '0;
                        end
                    end
                    S_OUTHI: begin
                        if (r_pc == '0) begin
                            r_fout <= {6'b0, j11hi};
                            r_hi0  <= j11hi;
                        end
                        if (r_pc == PW'(PH + 1)) begin
                            r_state <= r_hi0[6] ? S_IDLE : S_INIT;
                            r_abort <= r_abort & ~r_hi0[6];
                            r_pc    <= '0;
                        end
                    end
                    default: r_state <= S_INIT;
                endcase
            end
        end
    end
endmodule

// File: doc/j11busif2.md
# j11busif2

Parametrised successor DCJ11 bus interface. Generates the J11 clock, decodes J11 bus cycles (ALE/STRB/SCTL, multiplexed DAL via `j11dsel`) into a single-request system-bus handshake, and presents status/interrupt words on the high DAL bank whenever they change. It adds three capabilities to the fixed-timing interface:

- configurable clock divider;
- configurable data-select phase length;
- bus timeout that completes a hung cycle and raises J11 abort.

It sits between the DCJ11 pins and the system bus arbiter.

## Interface
- `CLKDIV`, 5: `clk` cycles per `j11clk` half-period (≥2).
- `PH`, 2: `clk` cycles `j11dsel` is held active per DAL phase (≥1).
- `TIMEOUT`, 255: `clk` cycles allowed for `busack` after `busreq` rises; 0 disables the timeout.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `j11f` inout 16: DAL bus; driven only while `fdrive`.
- `j11clk` out 1: J11 clock.
- `j11dmr`, `j11miss` out 1: constant 1, 0.
- `j11cont` out 1: continue, active low.
- `j11dv` out 1: data valid.
- `j11abortout` out 1: abort to J11.
- `j11dsel` out 4: DAL bank select.
  - NONE=1100, INHI=0100, INLO=1000, OUTHI=1110, OUTLO=1101.
- `j11ale`, `j11strb`, `j11sctl`, `j11map` in 1: async; 2-flop synchronised, flops preset to 1.
- `j11hi` in 10: {parity, event, fpe, init, halt, pwrf, irq[3:0]}; bit 6 = init.
- `busreq` out 1: request, held until `busack` or timeout.
- `buswr`, `busgp`, `busirq` out 1: write / general-purpose / IRQ-ack qualifiers.
- `busaddr` out 22: cycle address.
- `buswdata` out 16: write data.
- `busack` in 1: one-cycle acknowledge; read data valid on the same cycle.
- `busrdata` in 16: read data.
- `busto` out 1: one-cycle pulse on timeout.
- `j11state` out 5: current state, for debug.

## Operation
- `rst` applies the following, all synchronously:

  | Signal / register | Reset value |
  |---|---|
  | state | INIT |
  | `j11clk` | 0 |
  | divider | 0 |
  | `j11dsel` | NONE |
  | `j11cont` | 1 |
  | `j11dv`, `j11abortout`, `busreq`, `busto` | 0 |
  | `fdrive` | 0 |
  | `hi0` (last presented status) | 0 |
  | `busaddr`, `buswdata`, `fout` | 0 |

- `rst` mid-cycle abandons the cycle: `busreq` drops, `j11f` is released.
- Divider toggles `j11clk` every `CLKDIV` cycles, independent of the FSM.
- Phase sequence for each DAL transfer: 1 cycle NONE (setup), `PH` cycles with the select active, 1 cycle NONE (hold). The sample or drive point is the last active cycle.
- States and transitions:
  - INIT: leave for OUTHI when `j11hi`≠`hi0`.
  - IDLE: rising STRB → WAITALE. Otherwise, if `j11hi`≠`hi0` → OUTHI. STRB wins when both occur.
  - WAITALE: `ale`=0 → ADDR.
  - ADDR: INHI phase, then INLO phase.
    - End of INHI phase latches `busaddr[21:16]`=f[5:0], aio=f[11:8], abort flag=f[13].
    - It also sets `busgp` = (aio==1110 or aio==0101) and `busirq` = (aio==1101).
    - End of INLO phase latches `busaddr[15:0]`.
    - Then: aio=1111 → WREND; aio[3]=1 → RDREQ; else → WRWAIT.
  - RDREQ: `busreq`=1, `buswr`=0.
    - On `busack`: `fout`←`busrdata`, go to RDOUT.
    - On timeout: `fout`←16'hFFFF, `j11abortout`=1, `busto` pulse, go to RDOUT.
  - RDOUT: `fdrive`=1 for the whole phase, OUTLO during the active cycles; then RDEND0.
  - RDEND0: `sctl`=0 → RDEND1.
  - RDEND1: `j11dv`=1, `j11cont`=0. On `sctl`=1, go to OUTHI if `j11hi`≠`hi0`, else IDLE.
  - WRWAIT: INLO held; `sctl`=0 → WRREQ. `buswdata` samples `j11f` every cycle of WRWAIT.
  - WRREQ: `busreq`=1, `buswr`=1. On `busack` or timeout → WREND. Timeout also sets `j11abortout` and pulses `busto`.
  - WREND: `j11cont`=0. On `sctl`=1, go to OUTHI if `j11hi`≠`hi0`, else IDLE.
  - OUTHI: on entry, `fout`←`{6'b0, j11hi}` and `hi0`←`j11hi`. `fdrive`=1 for the phase, OUTHI during the active cycles. Exit to INIT if init bit is 0, else IDLE.
- A falling edge on the init bit of `j11hi` forces OUTHI from any state and abandons the bus cycle (`busreq` drops).
- `j11abortout` clears on return to IDLE.

## Timing
- Synchroniser latency: 2 cycles.
- STRB rise → first INHI: 3 cycles minimum (WAITALE 1 cycle if `ale` is already 0).
- `busreq` rises the cycle after entry to RDREQ/WRREQ. It falls the cycle after `busack`, or after `TIMEOUT` cycles with no ack.
- Timeout counter resets on each request. Expiry occurs on cycle `TIMEOUT` counted from the `busreq` rise.
- `busack` coincident with the expiry cycle counts as an ack: no abort.
- Read: `busack` → OUTLO active after 2 cycles (1 state cycle + 1 setup).
- OUTHI and RDOUT each last `PH`+2 cycles.

## Test plan
- **Reset:** `rst` 1 cycle with `j11hi`=0 → all outputs at their reset values; state INIT; no change on `j11f` for 20 cycles.
- **Status:** `j11hi`=10'h040 from INIT → OUTHI with `j11f`=16'h0040 driven during OUTHI select (PH=2 → 2 cycles) → IDLE.
- **Read:** DAL hi=16'h0803, lo=16'h1234; `busack` 3 cycles after `busreq` with `busrdata`=16'hBEEF.
  - `busaddr`=22'h031234, `buswr`=0.
  - `j11f`=BEEF under OUTLO.
  - `j11dv` high until `sctl` rises.
- **Write:** aio=0101, `j11f`=16'h5A5A in WRWAIT → `buswr`=1, `busgp`=1, `buswdata`=5A5A; WREND `j11cont`=0.
- **Timeout:** TIMEOUT=8, read with no `busack` → `busreq` falls after 8 cycles; `busto` pulse; `j11abortout`=1; `j11f`=FFFF.
- **Init fall:** init bit falls during WRREQ → `busreq` 0 next cycle; OUTHI; then INIT.
